// File: rtl/irq_ctrl.sv
// Interrupt, fault and break-continue front-end for the microcoded control unit.
// Synchronises requests, prioritises them and tracks trap entry / return bookkeeping.
module irq_ctrl #(
  parameter int unsigned NIRQ = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            fault_in,
  input  logic            cont_in,
  input  logic [3:0]      state,
  input  logic            RETI,
  input  logic            SYSCALL,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_data,
  input  logic            ie_set,
  input  logic            ie_clr,
  output logic            irq_r,
  output logic            fault_r,
  output logic            cont_r,
  output logic [3:0]      cause,
  output logic            in_service,
  output logic [NIRQ-1:0] pending,
  output logic            ie
);

  typedef enum logic [3:0] {
    ST_TRAP  = 4'd0,
    ST_EXECM = 4'd8,
    ST_BREAK = 4'd9
  } dec_state_e;

  logic [NIRQ-1:0] r_irq_s1, r_irq_s2, r_irq_s3;
  logic            r_cont_s1, r_cont_s2, r_cont_s3;
  logic [NIRQ-1:0] r_mask, r_pending;
  logic            r_irq, r_fault, r_cont, r_in_service, r_ie;
  logic [3:0]      r_cause;

  logic [NIRQ-1:0] w_irq_edge, w_req, w_clr;
  logic            w_cont_edge, w_cand_vld, w_found;
  logic [3:0]      w_cand;
  logic            w_trap, w_take_flt, w_take_irq, w_take_sys, w_entry, w_reti;

  assign w_irq_edge  = r_irq_s2 & ~r_irq_s3;
  assign w_cont_edge = r_cont_s2 & ~r_cont_s3;
  assign w_req       = r_pending & r_mask;
  assign w_cand_vld  = |w_req;

  // Lowest enabled pending line wins.
  always_comb begin
    w_cand  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (w_req[i] && !w_found) begin
        w_cand  = 4'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_trap     = (state == ST_TRAP);
    w_take_flt = w_trap & r_fault;
    w_take_irq = w_trap & r_irq & ~r_fault;
    w_take_sys = SYSCALL & ~r_in_service;
    w_entry    = w_take_flt | w_take_irq | w_take_sys;
    w_reti     = RETI & (state == ST_EXECM);
    w_clr      = '0;
    if (w_take_irq && w_cand_vld) w_clr = {{(NIRQ-1){1'b0}}, 1'b1} << w_cand;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_s1     <= '0;
      r_irq_s2     <= '0;
      r_irq_s3     <= '0;
      r_cont_s1    <= 1'b0;
      r_cont_s2    <= 1'b0;
      r_cont_s3    <= 1'b0;
      r_mask       <= '0;
      r_pending    <= '0;
      r_irq        <= 1'b0;
      r_fault      <= 1'b0;
      r_cont       <= 1'b0;
      r_in_service <= 1'b0;
      r_ie         <= 1'b0;
      r_cause      <= '0;
    end else begin
      r_irq_s1  <= irq_in;
      r_irq_s2  <= r_irq_s1;
      r_irq_s3  <= r_irq_s2;
      r_cont_s1 <= cont_in;
      r_cont_s2 <= r_cont_s1;
      r_cont_s3 <= r_cont_s2;

      if (mask_we) r_mask <= mask_data;
      // A fresh edge on the line being accepted re-arms its pending bit.
      r_pending <= (r_pending & ~w_clr) | w_irq_edge;

      if (w_take_irq || r_fault)
        r_irq <= 1'b0;
      else if (!r_irq)
        r_irq <= r_ie & ~r_in_service & w_cand_vld & (state == ST_EXECM);

      r_fault <= fault_in | (r_fault & ~w_trap);

      if (w_take_flt)      r_cause <= 4'd9;
      else if (w_take_irq) r_cause <= w_cand;
      else if (w_take_sys) r_cause <= 4'd8;

      if (w_entry)     r_in_service <= 1'b1;
      else if (w_reti) r_in_service <= 1'b0;

      if (ie_clr || w_entry)     r_ie <= 1'b0;
      else if (ie_set || w_reti) r_ie <= 1'b1;

      r_cont <= (state == ST_BREAK) & (r_cont | w_cont_edge);
    end
  end

  assign irq_r      = r_irq;
  assign fault_r    = r_fault;
  assign cont_r     = r_cont;
  assign cause      = r_cause;
  assign in_service = r_in_service;
  assign pending    = r_pending;
  assign ie         = r_ie;

endmodule
